// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences one multi-cycle multiply through an external multiplier,
// holds its operands stable while it runs, and owns the HI/LO result
// registers. These registers are also written by mthi/mtlo moves.
module mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mul_req,
  input  logic        ex_mul_signed,
  input  logic [31:0] ex_src1,
  input  logic [31:0] ex_src2,
  input  logic        ex_hi_we,
  input  logic        ex_lo_we,
  input  logic [31:0] ex_hilo_wdata,
  output logic        mul_start_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mul_result_i,
  input  logic        mul_ready_i,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        op_load;
  logic        hi_load;
  logic        lo_load;
  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic [31:0] op1_reg;
  logic [31:0] op2_reg;
  logic        signed_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  // State register; reset abandons any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, stall request and HI/LO write selection.
  // Moves are only honoured when no multiply is being launched or running.
  always_comb begin
    state_next = state_reg;
    op_load    = 1'b0;
    hi_load    = 1'b0;
    lo_load    = 1'b0;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    stallreq_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ex_mul_req) begin
          stallreq_o = 1'b1;
          op_load    = 1'b1;
          state_next = BUSY;
        end else begin
          hi_load = ex_hi_we;
          lo_load = ex_lo_we;
          hi_next = ex_hilo_wdata;
          lo_next = ex_hilo_wdata;
        end
      end
      BUSY: begin
        stallreq_o = 1'b1;
        if (mul_ready_i) begin
          hi_load    = 1'b1;
          lo_load    = 1'b1;
          hi_next    = mul_result_i[63:32];
          lo_next    = mul_result_i[31:0];
          state_next = DONE;
        end
      end
      DONE: begin
        // The finished instruction is still in EX; its request is ignored.
        hi_load    = ex_hi_we;
        lo_load    = ex_lo_we;
        hi_next    = ex_hilo_wdata;
        lo_next    = ex_hilo_wdata;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture at launch; held untouched until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_reg    <= 32'd0;
      op2_reg    <= 32'd0;
      signed_reg <= 1'b0;
    end else if (op_load) begin
      op1_reg    <= ex_src1;
      op2_reg    <= ex_src2;
      signed_reg <= ex_mul_signed;
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else begin
      if (hi_load) begin
        hi_reg <= hi_next;
      end
      if (lo_load) begin
        lo_reg <= lo_next;
      end
    end
  end

  // Start is a pure decode of the state register.
  assign mul_start_o  = (state_reg == BUSY);
  assign mul_signed_o = signed_reg;
  assign mul_op1_o    = op1_reg;
  assign mul_op2_o    = op2_reg;
  assign hi_o         = hi_reg;
  assign lo_o         = lo_reg;

endmodule
